// File: rtl/rot_imm_pkg.sv
// Shared types, widths and helpers for the rotated-immediate encoder.
package rot_imm_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned ROT_W           = 4;
    localparam int unsigned IMM8_W          = 8;
    localparam int unsigned IMM12_W         = ROT_W + IMM8_W;
    localparam int unsigned CNT_W           = 5;
    localparam int unsigned SHAMT_W         = 5;
    localparam int unsigned CAND_LAST_PLAIN = 15;
    localparam int unsigned CAND_LAST_INV   = 31;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } state_e;

    typedef struct packed {
        logic [ROT_W-1:0]  rot;
        logic [IMM8_W-1:0] imm8;
    } imm12_t;

    // Rotate left; k==0 is handled separately so we never shift by DATA_W.
    function automatic logic [DATA_W-1:0] rol32(input logic [DATA_W-1:0] x,
                                                input logic [SHAMT_W-1:0] k);
        logic [SHAMT_W:0] rk;
        if (k == SHAMT_W'(0)) begin
            return x;
        end
        rk = (SHAMT_W+1)'(DATA_W) - {1'b0, k};
        return (x << k) | (x >> rk);
    endfunction

endpackage

// File: rtl/rot_candidate_check.sv
// Tests one (operand, rotation) candidate: does ROL(x, 2r) fit in 8 bits?
module rot_candidate_check
    import rot_imm_pkg::*;
(
    input  logic [DATA_W-1:0] x_i,
    input  logic [ROT_W-1:0]  r_i,
    output logic              hit_o,
    output logic [IMM8_W-1:0] imm8_o,
    output logic              carry_o
);

    logic [DATA_W-1:0] rotated;

    always_comb begin
        rotated = rol32(x_i, {r_i, 1'b0});
        hit_o   = (rotated[DATA_W-1:IMM8_W] == (DATA_W-IMM8_W)'(0));
        imm8_o  = rotated[IMM8_W-1:0];
        // Expanded immediate equals x_i, so its MSB is x_i[31] for nonzero rotations.
        carry_o = (r_i != ROT_W'(0)) ? x_i[DATA_W-1] : 1'b0;
    end

endmodule

// File: rtl/rotated_imm_encoder.sv
// Iterative inverse of the immediate shifter-operand decode: one candidate per clock.
module rotated_imm_encoder
    import rot_imm_pkg::*;
#(
    parameter bit ALLOW_INVERT = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [DATA_W-1:0]  value,
    output logic               busy,
    output logic               done,
    output logic               valid,
    output logic [IMM12_W-1:0] imm12,
    output logic               inverted,
    output logic               carry_out
);

    localparam logic [CNT_W-1:0] CAND_LAST =
        ALLOW_INVERT ? CNT_W'(CAND_LAST_INV) : CNT_W'(CAND_LAST_PLAIN);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    imm12_t            imm12_q, imm12_d;
    logic              inverted_q, inverted_d;
    logic              carry_q, carry_d;

    logic [DATA_W-1:0] operand;
    logic              cand_hit;
    logic [IMM8_W-1:0] cand_imm8;
    logic              cand_carry;

    assign operand = cnt_q[CNT_W-1] ? ~val_q : val_q;

    rot_candidate_check u_check (
        .x_i     (operand),
        .r_i     (cnt_q[ROT_W-1:0]),
        .hit_o   (cand_hit),
        .imm8_o  (cand_imm8),
        .carry_o (cand_carry)
    );

    // Next-state and result logic; done is a single-cycle pulse by default-low.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        val_d      = val_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        imm12_d    = imm12_q;
        inverted_d = inverted_q;
        carry_d    = carry_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SEARCH;
                    val_d      = value;
                    cnt_d      = CNT_W'(0);
                    busy_d     = 1'b1;
                    valid_d    = 1'b0;
                    imm12_d    = imm12_t'(0);
                    inverted_d = 1'b0;
                    carry_d    = 1'b0;
                end
            end
            ST_SEARCH: begin
                if (cand_hit) begin
                    state_d      = ST_IDLE;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    valid_d      = 1'b1;
                    imm12_d.rot  = cnt_q[ROT_W-1:0];
                    imm12_d.imm8 = cand_imm8;
                    inverted_d   = cnt_q[CNT_W-1];
                    carry_d      = cand_carry;
                end else if (cnt_q == CAND_LAST) begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    valid_d    = 1'b0;
                    imm12_d    = imm12_t'(0);
                    inverted_d = 1'b0;
                    carry_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_W'(0);
            val_q      <= DATA_W'(0);
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            imm12_q    <= imm12_t'(0);
            inverted_q <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            val_q      <= val_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            imm12_q    <= imm12_d;
            inverted_q <= inverted_d;
            carry_q    <= carry_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign valid     = valid_q;
    assign imm12     = imm12_q;
    assign inverted  = inverted_q;
    assign carry_out = carry_q;

endmodule

// File: doc/rotated_imm_encoder.md
Name: rotated_imm_encoder

Overview:
Iterative encoder that converts a 32-bit constant into the data-processing immediate shifter-operand form {rotate_imm[3:0], immed_8[7:0]}. The operand decode stage expands that field as ROR(zero-extended immed_8, 2*rotate_imm); this block performs the inverse. It searches one candidate per clock, optionally trying the bitwise-inverted value (MOV/MVN substitution). It sits beside the datapath, feeding the instruction builder and the self-test constant loader.

Parameters:
ALLOW_INVERT, 1, when 1 search the inverted value after the plain value (32 candidates); when 0 search plain only (16 candidates).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
value  input  32  constant to encode; latched when start is accepted
busy  output  1  high while searching
done  output  1  one-cycle pulse when the result is final
valid  output  1  1 = encodable; held until next accepted start
imm12  output  12  {rotate_imm, immed_8}; 0 when valid=0
inverted  output  1  1 = encoding is of ~value (use MVN)
carry_out  output  1  shifter carry the decoder produces for imm12: 0 if rotate_imm==0, else bit 31 of the expanded immediate

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE; busy, done, valid, imm12, inverted, carry_out all 0; candidate counter 0. Applies mid-search; the search is abandoned and no done is issued.
- States: IDLE, SEARCH. There is no separate DONE state.
- IDLE: start=1 latches value into val_q, clears the counter, and goes to SEARCH. busy=1 from the next cycle. valid, imm12, inverted and carry_out are cleared on acceptance.
- SEARCH, counter c (5 bits):
  - Operand X is val_q for c<16, ~val_q for c>=16.
  - r = c[3:0]; t = ROL(X, 2*r).
  - Hit if t[31:8]==0.
- On a hit: register valid=1, imm12={r, t[7:0]}, inverted=c[4], carry_out=(r!=0) ? X[31] : 0. Pulse done=1, then return to IDLE with busy=0.
- On a miss at the last candidate (c=15 if ALLOW_INVERT=0, else c=31): valid=0, imm12=0, inverted=0, carry_out=0. Pulse done=1, then return to IDLE.
- Otherwise c increments.
- Priority: the first hit in candidate order wins. This means smallest rotation first, and plain before inverted.
- Latency: the result for candidate c is visible (done=1) c+1 cycles after the start-accept edge. Worst case is 16 or 32 cycles.
- start while busy=1 is ignored, and value changes during SEARCH have no effect.
- done is high for exactly one cycle. That cycle is already IDLE, so a start in the done cycle is accepted; back-to-back operation has no bubble.
- Width rules:
  - Rotation amount is 2*r, in the range 0..30; a rotation by 0 is identity.
  - ROL is implemented as (X<<k)|(X>>(32-k)) with the k=0 case guarded, so there is no shift by 32.
- Outputs are registered. There is no combinational path from start or value to any output.

Decomposition:
- Shared package rot_imm_pkg: state encoding (IDLE=0, SEARCH=1), ROT_W=4, IMM8_W=8, CAND_LAST_PLAIN=15, CAND_LAST_INV=31.
- One combinational sub-module, rot_candidate_check (inputs X, r; outputs hit, imm8, carry). The top holds the FSM, counter and output registers.

Test Plan:
- value=0x000000FF, start -> done 1 cycle after accept; valid=1, imm12=0x0FF, inverted=0, carry_out=0.
- value=0xFF000000 -> done after 5 cycles; imm12=0x4FF, inverted=0, carry_out=1.
- value=0x000003FC -> done after 16 cycles; imm12=0xFFF, carry_out=0.
- value=0xFFFFFF00:
  - ALLOW_INVERT=1 -> done after 17 cycles; imm12=0x0FF, inverted=1.
  - ALLOW_INVERT=0 -> done after 16 cycles; valid=0, imm12=0.
- value=0x00000101 -> done after 32 cycles; valid=0, imm12=0, busy high for cycles 1-31. A start pulsed mid-search is ignored. A new start in the done cycle (value=0x0) gives done one cycle later with valid=1, imm12=0x000.
- reset_n=0 in search cycle 10 for value=0x00000101 -> next cycle all outputs 0, state IDLE, no done pulse. A subsequent start works normally.
